// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and divisor helper for the UART blocks
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    localparam int         OVERSAMPLE = 16;
    localparam int         MID_TICK   = 7;
    localparam logic [7:0] ASCII_DASH = 8'd45;

    // Clocks per oversample tick, truncated, never below 1.
    function automatic int uart_div(input int clk_hz, input int baud, input int ovs);
        int d;
        d = clk_hz / (baud * ovs);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one-cycle pulse every DIV clocks
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int            CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TOP = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || cnt_q == TOP) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tick = !clear && (cnt_q == TOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_ascii.sv
// rtl/uart_rx_ascii.sv - 8N1 UART receiver with a held copy of the last good byte
module uart_rx_ascii
    import uart_pkg::*;
#(
    parameter int         CLK_FREQ_HZ = 50_000_000,
    parameter int         BAUD        = 9600,
    parameter int         OVERSAMPLE  = 16,
    parameter logic [7:0] RESET_CHAR  = 8'd45
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [7:0] ascii_hold,
    output logic       busy
);

    localparam int         DIV       = uart_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID       = 4'(MID_TICK);

    logic        sync1_q, rx_s_q;
    uart_state_e state_q, state_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  ascii_hold_q, ascii_hold_d;
    logic        busy_q, busy_d;
    logic        tick;
    logic        tick_clear;

    // Holding the divider in IDLE aligns every tick to the detected start edge.
    assign tick_clear = (state_q == IDLE) || (state_q == BREAK);

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        ascii_hold_d = ascii_hold_q;
        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                bit_idx_d  = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == MID) begin
                        tick_cnt_d = '0;
                        state_d    = rx_s_q ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d = '0;
                        rx_data_d  = shift_q;
                        if (rx_s_q) begin
                            rx_valid_d   = 1'b1;
                            ascii_hold_d = shift_q;
                            state_d      = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            BREAK: begin
                // A line held low must go high before a new start is accepted.
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            ascii_hold_q <= RESET_CHAR;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= rx;
            rx_s_q       <= sync1_q;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            ascii_hold_q <= ascii_hold_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign ascii_hold = ascii_hold_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ascii.sv
// tb/tb_uart_rx_ascii.sv - self-checking bench for uart_rx_ascii
module tb_uart_rx_ascii;

    localparam int BIT_CLK = 160;
    localparam int LAT_MIN = 1520;
    localparam int LAT_MAX = 1520 + 10 + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic [7:0] ascii_hold;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        bit         is_valid;
        logic [7:0] data;
        logic [7:0] hold;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         gap;
        bit         exp_valid;
        logic [7:0] exp_hold;
    } vec_t;

    ev_t obs_q[$];
    ev_t exp_q[$];

    uart_rx_ascii #(
        .CLK_FREQ_HZ (1_600_000),
        .BAUD        (10_000),
        .OVERSAMPLE  (16),
        .RESET_CHAR  (8'd45)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .ascii_hold (ascii_hold),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    logic       prev_valid = 1'b0;
    logic       prev_rst   = 1'b0;
    logic [7:0] prev_hold  = 8'd0;
    always @(negedge clk) begin
        if (rst_n && (rx_valid || frame_err)) begin
            chk("strobes_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
            obs_q.push_back('{rx_valid, rx_data, ascii_hold, cyc});
        end
        if (rst_n && prev_rst && ascii_hold !== prev_hold)
            chk("hold_changes_only_on_valid", {31'd0, rx_valid}, 32'd1);
        if (rx_valid)
            chk("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
        prev_valid = rx_valid;
        prev_rst   = rst_n;
        prev_hold  = ascii_hold;
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    // Called on a negedge; returns the cycle stamp of the start edge.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, output int start);
        start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_ok);
        if (!stop_ok) begin
            repeat (500) @(negedge clk);
            chk("busy_held_in_break", {31'd0, busy}, 32'd1);
            rx = 1'b1;
        end
    endtask

    task automatic check_events();
        int n;
        chk("event_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("ev%0d_kind", i), {31'd0, obs_q[i].is_valid}, {31'd0, exp_q[i].is_valid});
            chk($sformatf("ev%0d_rx_data", i), {24'd0, obs_q[i].data}, {24'd0, exp_q[i].data});
            chk($sformatf("ev%0d_hold", i), {24'd0, obs_q[i].hold}, {24'd0, exp_q[i].hold});
            chk_range($sformatf("ev%0d_latency", i), obs_q[i].cyc - exp_q[i].cyc, LAT_MIN, LAT_MAX);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    vec_t       vecs[8];
    logic [7:0] hold_m;

    initial begin
        int         st;
        logic [7:0] b;
        bit         ok;
        int         gap;

        vecs[0] = '{8'h33, 1'b1, 300, 1'b1, 8'h33};
        vecs[1] = '{8'h41, 1'b1,   0, 1'b1, 8'h41};
        vecs[2] = '{8'h62, 1'b1, 300, 1'b1, 8'h62};
        vecs[3] = '{8'h55, 1'b0, 300, 1'b0, 8'h62};
        vecs[4] = '{8'h00, 1'b1, 200, 1'b1, 8'h00};
        vecs[5] = '{8'hFF, 1'b1,   0, 1'b1, 8'hFF};
        vecs[6] = '{8'hA5, 1'b0, 200, 1'b0, 8'hFF};
        vecs[7] = '{8'h80, 1'b1, 300, 1'b1, 8'h80};

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_hold", {24'd0, ascii_hold}, 32'd45);
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_strobes", {30'd0, rx_valid, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        chk("idle_hold", {24'd0, ascii_hold}, 32'd45);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        check_events();

        // Short low glitch must be rejected at the mid-start check.
        rx = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_busy_high", {31'd0, busy}, 32'd1);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_busy_low", {31'd0, busy}, 32'd0);
        chk("glitch_hold", {24'd0, ascii_hold}, 32'd45);
        check_events();

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_ok, st);
            exp_q.push_back('{vecs[i].exp_valid, vecs[i].data, vecs[i].exp_hold, st});
            repeat (vecs[i].gap) @(negedge clk);
            if (vecs[i].gap > 0) begin
                chk($sformatf("vec%0d_hold_out", i), {24'd0, ascii_hold}, {24'd0, vecs[i].exp_hold});
                chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
            end
        end
        check_events();

        // Randomized frames against the reference model.
        hold_m = 8'h80;
        for (int i = 0; i < 10; i++) begin
            b   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, 300);
            send_frame(b, ok, st);
            if (ok) hold_m = b;
            exp_q.push_back('{ok, b, hold_m, st});
            repeat (gap) @(negedge clk);
        end
        repeat (50) @(negedge clk);
        chk("rand_hold_out", {24'd0, ascii_hold}, {24'd0, hold_m});
        check_events();

        // Reset in the middle of data bit 4 of 0x39 aborts the frame.
        b = 8'h39;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        repeat (80) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_async_hold", {24'd0, ascii_hold}, 32'd45);
        chk("abort_async_busy", {31'd0, busy}, 32'd0);
        chk("abort_async_rx_data", {24'd0, rx_data}, 32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("abort_hold_after", {24'd0, ascii_hold}, 32'd45);
        obs_q.delete();
        send_frame(8'h37, 1'b1, st);
        exp_q.push_back('{1'b1, 8'h37, 8'h37, st});
        repeat (50) @(negedge clk);
        chk("abort_then_37_hold", {24'd0, ascii_hold}, 32'h37);
        check_events();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
